snake_pixel_renderer: RTL and testbench
=======================================

# snake_pixel_renderer

Pixel renderer: the stage directly downstream of the symbol ROM in the display path. It receives VGA raster coordinates and tracks the grid cell and symbol pixel under the beam with incremental counters, so no divider is needed. It fetches the cell's figure code from game-state memory and forwards it to the symbol ROM. It then extracts the 2-bit pixel code from the returned 50-bit symbol word and drives palette-mapped RGB with sync delayed to match.

## Interface
Parameters:
- SCALE, 4: screen pixels per symbol pixel, per axis. A cell is 5·SCALE pixels square.
- GRID_W, 32: cells per row.
- GRID_H, 24: cells per column.
- H_ACTIVE, 640: active pixels per line.
- V_ACTIVE, 480: active lines per frame.

Ports:
- clock_25, in, 1: pixel clock; all state on rising edge.
- reset, in, 1: asynchronous, active-high.
- pixel_x, in, 10: raster column from VGA timing generator.
- pixel_y, in, 10: raster line.
- video_on, in, 1: active-area flag.
- hsync_in, in, 1: horizontal sync from timing generator.
- vsync_in, in, 1: vertical sync from timing generator.
- cell_x, out, 5: grid column of the current pixel, to game-state memory.
- cell_y, out, 5: grid row of the current pixel.
- cell_figure, in, 4: figure code returned by game-state memory 1 cycle after cell_x/cell_y.
- selected_figure, out, 4: figure code sent to the symbol ROM.
- selected_symbol, in, 50: symbol word returned 1 cycle after selected_figure.
- vga_r, out, 4: red channel.
- vga_g, out, 4: green channel.
- vga_b, out, 4: blue channel.
- hsync, out, 1: delay-matched horizontal sync.
- vsync, out, 1: delay-matched vertical sync.

## Operation
- Horizontal counters: sub_x (0..SCALE-1), px (0..4), cx (0..GRID_W-1).
  - Cleared when pixel_x==0.
  - Otherwise advance once per cycle while video_on: sub_x wraps into px, px wraps into cx.
  - cx saturates at GRID_W-1 and sets in_grid_x=0 beyond the grid.
- Vertical counters: sub_y, py, cy, same structure.
  - Advance once per line on the cycle pixel_x==H_ACTIVE-1.
  - Cleared when pixel_y>=V_ACTIVE.
- cell_x=cx and cell_y=cy are driven from registers for the pixel presented in the same cycle (stage 0).
- Stage 1:
  - selected_figure = cell_figure when the delayed in_grid flag is 1, else 4'd10 (blank code).
  - px/py/in_grid/video_on/syncs are carried alongside.
- Stage 2: k = py·5 + px (0..24). code = selected_symbol[49-2k -: 2]; the MSB pair is pixel (px=0, py=0), scanning x first.
- Stage 3 (registered output), palette:
  - 00 → background 0x000.
  - 01 → snake green 0x0C0.
  - 10 → cherry red 0xF00.
  - 11 → eye white 0xFFF.
  - Outside the grid but video_on → border 0x444.
  - video_on low → 0x000.
- Figure codes 10..15 arrive as all-zero words and render as background; no special-casing is needed.

## Timing
- Reset values: all counters 0, in_grid 0; vga_r/g/b 0; hsync/vsync 1 (idle high); selected_figure 4'd10; cell_x/cell_y 0.
- Latency: 3 cycles from pixel_x/pixel_y presentation to vga_*. hsync/vsync/video_on pass through a 3-stage delay line, so color and sync remain aligned.
- Throughput: one pixel per cycle, no stalls. Upstream memories have a fixed 1-cycle registered read latency; there is no handshake.
- Wrap boundaries:
  - px 4→0 increments cx on the same edge.
  - cx at GRID_W-1 with px=4, sub_x=SCALE-1 → in_grid_x drops next cycle.
- Simultaneous end-of-line and end-of-frame (pixel_x==H_ACTIVE-1, pixel_y==V_ACTIVE-1): vertical clear has priority over advance.
- Reset mid-frame: the pipeline flushes to black immediately. Counters resynchronise at the next pixel_x==0 / pixel_y>=V_ACTIVE.

## Configuration
- GRID_LINES_EN defined:
  - Background pixels (code 00) where sub_x==0 && px==0, or sub_y==0 && py==0, render grid color 0x222.
  - The flags are delayed with the pipeline.
- GRID_LINES_EN undefined: those pixels render 0x000. The flags and their delay registers are removed.

## Test plan
- Reset asserted mid-line → next edge vga_*=0, hsync=vsync=1, selected_figure=10. Release → first correct pixel 3 cycles after the next pixel_x==0.
- Walk line 0 with SCALE=4 → cell_x increments every 20 cycles (0,1,…,31). At pixel_x==640, in_grid=0, border 0x444 shown while video_on.
- cell_figure=4 (body, all 01) at cell (3,2) → pixels x=60..79, y=40..59 output 0x0C0, appearing 3 cycles after presentation.
- Symbol word with only bits[49:48]=11 → only screen pixels sub-block px=0, py=0 (4×4) white; all others background. With GRID_LINES_EN, cell-edge column/row is 0x222.
- cherry code 9 → the code-10 pixels of the cherry symbol render 0xF00 and the code-01 stem pixels render 0x0C0. Figure 12 → entire cell background.
- Toggle hsync_in/vsync_in at arbitrary cycles → hsync/vsync reproduce them exactly 3 cycles later.

Source files
------------

// File: rtl/snake_pixel_renderer.sv
// Snake pixel renderer: raster -> grid cell / symbol pixel -> palette RGB, 3-cycle latency.
// Optional GRID_LINES_EN draws 0x222 cell-edge lines over background pixels.
module snake_pixel_renderer #(
  parameter int SCALE    = 4,
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        clock_25,
  input  logic        reset,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [4:0]  cell_x,
  output logic [4:0]  cell_y,
  input  logic [3:0]  cell_figure,
  output logic [3:0]  selected_figure,
  input  logic [49:0] selected_symbol,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hsync,
  output logic        vsync
);

  localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;

  typedef struct packed {
    logic [SW-1:0] sub;
    logic [2:0]    p;
    logic [4:0]    c;
    logic          ing;
  } axis_t;

  typedef struct packed {
    logic [2:0] px;
    logic [2:0] py;
    logic       ing;
    logic       vid;
    logic       hs;
    logic       vs;
`ifdef GRID_LINES_EN
    logic       ex;
    logic       ey;
`endif
  } stg_t;

  localparam axis_t AX_CLR = '{sub: '0, p: 3'd0, c: 5'd0, ing: 1'b1};

  // sub wraps into p, p wraps into c; stepping past the last cell drops ing and freezes
  function automatic axis_t adv(input axis_t a, input logic [4:0] cmax);
    adv = a;
    if (a.ing) begin
      if (a.sub != SW'(SCALE-1)) adv.sub = a.sub + 1'b1;
      else begin
        adv.sub = '0;
        if (a.p != 3'd4) adv.p = a.p + 3'd1;
        else begin
          adv.p = 3'd0;
          if (a.c != cmax) adv.c = a.c + 5'd1;
          else             adv.ing = 1'b0;
        end
      end
    end
  endfunction

  axis_t r_hx, r_vy, w_hx;
  stg_t  w_s0, r_s1, r_s2;
  logic [4:0]  w_k;
  logic [5:0]  w_lo;
  logic [1:0]  w_code;
  logic [11:0] w_rgb, r_rgb;
  logic        r_hs, r_vs;

  assign w_hx   = (pixel_x == 10'd0) ? AX_CLR : r_hx;
  assign cell_x = w_hx.c;
  assign cell_y = r_vy.c;

  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) begin
      r_hx <= '0;
      r_vy <= '0;
    end else begin
      r_hx <= video_on ? adv(w_hx, 5'(GRID_W-1)) : w_hx;
      // clearing wins over the end-of-line advance on the last active line
      if (pixel_y >= 10'(V_ACTIVE) ||
          (pixel_x == 10'(H_ACTIVE-1) && pixel_y == 10'(V_ACTIVE-1)))
        r_vy <= AX_CLR;
      else if (pixel_x == 10'(H_ACTIVE-1))
        r_vy <= adv(r_vy, 5'(GRID_H-1));
    end
  end

  always_comb begin
    w_s0     = '0;
    w_s0.px  = w_hx.p;
    w_s0.py  = r_vy.p;
    w_s0.ing = w_hx.ing & r_vy.ing;
    w_s0.vid = video_on;
    w_s0.hs  = hsync_in;
    w_s0.vs  = vsync_in;
`ifdef GRID_LINES_EN
    w_s0.ex  = (w_hx.sub == '0) && (w_hx.p == 3'd0);
    w_s0.ey  = (r_vy.sub == '0) && (r_vy.p == 3'd0);
`endif
  end

  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) begin
      r_s1    <= '0;
      r_s1.hs <= 1'b1;
      r_s1.vs <= 1'b1;
      r_s2    <= '0;
      r_s2.hs <= 1'b1;
      r_s2.vs <= 1'b1;
    end else begin
      r_s1 <= w_s0;
      r_s2 <= r_s1;
    end
  end

  assign selected_figure = r_s1.ing ? cell_figure : 4'd10;

  // pixel k lives at bits [49-2k -: 2]
  assign w_k    = 5'(r_s2.py) * 5'd5 + 5'(r_s2.px);
  assign w_lo   = 6'd48 - {w_k, 1'b0};
  assign w_code = {selected_symbol[w_lo + 6'd1], selected_symbol[w_lo]};

  always_comb begin
    w_rgb = 12'h000;
    if (r_s2.vid) begin
      if (!r_s2.ing) w_rgb = 12'h444;
      else begin
        case (w_code)
`ifdef GRID_LINES_EN
          2'b00:   w_rgb = (r_s2.ex | r_s2.ey) ? 12'h222 : 12'h000;
`else
          2'b00:   w_rgb = 12'h000;
`endif
          2'b01:   w_rgb = 12'h0C0;
          2'b10:   w_rgb = 12'hF00;
          default: w_rgb = 12'hFFF;
        endcase
      end
    end
  end

  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) begin
      r_rgb <= 12'h000;
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
    end else begin
      r_rgb <= w_rgb;
      r_hs  <= r_s2.hs;
      r_vs  <= r_s2.vs;
    end
  end

  assign vga_r = r_rgb[11:8];
  assign vga_g = r_rgb[7:4];
  assign vga_b = r_rgb[3:0];
  assign hsync = r_hs;
  assign vsync = r_vs;

endmodule

// File: tb/tb_snake_pixel_renderer.sv
// Directed bench for snake_pixel_renderer with behavioural game-state memory and symbol ROM.
module tb_snake_pixel_renderer;

  logic        clock_25 = 1'b0;
  logic        reset;
  logic [9:0]  pixel_x, pixel_y;
  logic        video_on, hsync_in, vsync_in;
  logic [4:0]  cell_x, cell_y;
  logic [3:0]  cell_figure;
  logic [3:0]  selected_figure;
  logic [49:0] selected_symbol;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        hsync, vsync;

  snake_pixel_renderer dut (
    .clock_25(clock_25), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .cell_x(cell_x), .cell_y(cell_y), .cell_figure(cell_figure),
    .selected_figure(selected_figure), .selected_symbol(selected_symbol),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .hsync(hsync), .vsync(vsync)
  );

  always #20 clock_25 = ~clock_25;

`ifdef GRID_LINES_EN
  localparam logic [11:0] BG_E = 12'h222;
`else
  localparam logic [11:0] BG_E = 12'h000;
`endif

  function automatic logic [3:0] fig_of(input logic [4:0] cx, input logic [4:0] cy);
    fig_of = 4'd0;
    if (cx == 5'd1 && cy == 5'd0) fig_of = 4'd6;
    if (cx == 5'd3 && cy == 5'd2) fig_of = 4'd4;
    if (cx == 5'd5 && cy == 5'd2) fig_of = 4'd9;
    if (cx == 5'd7 && cy == 5'd2) fig_of = 4'd12;
  endfunction

  // 4: all 01; 6: only pixel 0 = 11; 9: stem 01 at k=2, red 10 at k=12
  function automatic logic [49:0] rom(input logic [3:0] f);
    rom = '0;
    case (f)
      4'd4: rom = 50'h1555555555555;
      4'd6: rom = 50'h3 << 48;
      4'd9: rom = (50'h1 << 44) | (50'h1 << 25);
      default: rom = '0;
    endcase
  endfunction

  always @(posedge clock_25) begin
    cell_figure     <= fig_of(cell_x, cell_y);
    selected_symbol <= rom(selected_figure);
  end

  int nvec = 0, nfail = 0, cyc = 0;
  int b0, b40, b48, br;
  logic [11:0] rgb_log [0:4095];
  logic        hs_log  [0:4095];
  logic        vs_log  [0:4095];
  logic        hin_log [0:4095];
  logic        vin_log [0:4095];
  logic [4:0]  cx_log  [0:4095];
  logic [4:0]  cy_log  [0:4095];
  logic [3:0]  sf_log  [0:4095];

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [9:0] x, input logic [9:0] y,
                      input logic von, input logic hs, input logic vs);
    pixel_x = x; pixel_y = y; video_on = von; hsync_in = hs; vsync_in = vs;
    #1;
    cx_log[cyc] = cell_x; cy_log[cyc] = cell_y;
    hin_log[cyc] = hs; vin_log[cyc] = vs;
    @(posedge clock_25); #1;
    rgb_log[cyc] = {vga_r, vga_g, vga_b};
    hs_log[cyc] = hsync; vs_log[cyc] = vsync; sf_log[cyc] = selected_figure;
    cyc++;
  endtask

  // pixel presented in step n appears in log slot n+2
  function automatic logic [11:0] out_of(input int n);
    out_of = rgb_log[n+2];
  endfunction

  task automatic walk(input logic [9:0] y, input int x0, input int x1, input int von_end);
    for (int x = x0; x <= x1; x++)
      step(10'(x), y, (x < von_end),
           !(x >= 656 && x < 752), !(y == 10'd0 && x >= 700 && x < 703));
  endtask

  initial begin
    reset = 1'b1;
    step(10'd5, 10'd7, 1'b1, 1'b0, 1'b0);
    step(10'd5, 10'd7, 1'b1, 1'b0, 1'b0);
    chk("rst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
    chk("rst_hs", {11'd0, hsync}, 12'd1);
    chk("rst_vs", {11'd0, vsync}, 12'd1);
    chk("rst_sf", {8'd0, selected_figure}, 12'd10);
    chk("rst_cx", {7'd0, cx_log[1]}, 12'd0);
    chk("rst_cy", {7'd0, cy_log[1]}, 12'd0);
    reset = 1'b0;

    step(10'd0, 10'd480, 1'b0, 1'b1, 1'b1);
    b0 = cyc;
    walk(10'd0, 0, 799, 644);
    chk("l0_cx0",   {7'd0, cx_log[b0+0]},   12'd0);
    chk("l0_cx19",  {7'd0, cx_log[b0+19]},  12'd0);
    chk("l0_cx20",  {7'd0, cx_log[b0+20]},  12'd1);
    chk("l0_cx40",  {7'd0, cx_log[b0+40]},  12'd2);
    chk("l0_cx639", {7'd0, cx_log[b0+639]}, 12'd31);
    chk("l0_cx640", {7'd0, cx_log[b0+640]}, 12'd31);
    chk("l0_x0",   out_of(b0+0),   BG_E);
    chk("l0_x20",  out_of(b0+20),  12'hFFF);
    chk("l0_x23",  out_of(b0+23),  12'hFFF);
    chk("l0_x24",  out_of(b0+24),  BG_E);
    chk("l0_x639", out_of(b0+639), BG_E);
    chk("l0_x640", out_of(b0+640), 12'h444);
    chk("l0_x643", out_of(b0+643), 12'h444);
    chk("l0_x644", out_of(b0+644), 12'h000);
    chk("l0_sf640", {8'd0, sf_log[b0+640]}, 12'd10);
    foreach (hs_log[i]) begin end
    chk("hs_655", {11'd0, hs_log[b0+655+2]}, {11'd0, hin_log[b0+655]});
    chk("hs_656", {11'd0, hs_log[b0+656+2]}, 12'd0);
    chk("hs_751", {11'd0, hs_log[b0+751+2]}, 12'd0);
    chk("hs_752", {11'd0, hs_log[b0+752+2]}, 12'd1);
    chk("vs_699", {11'd0, vs_log[b0+699+2]}, 12'd1);
    chk("vs_700", {11'd0, vs_log[b0+700+2]}, 12'd0);
    chk("vs_702", {11'd0, vs_log[b0+702+2]}, 12'd0);
    chk("vs_703", {11'd0, vs_log[b0+703+2]}, 12'd1);

    for (int y = 1; y < 40; y++) begin
      step(10'd0, 10'(y), 1'b0, 1'b1, 1'b1);
      step(10'd639, 10'(y), 1'b0, 1'b1, 1'b1);
    end
    b40 = cyc;
    walk(10'd40, 0, 159, 640);
    step(10'd639, 10'd40, 1'b0, 1'b1, 1'b1);
    chk("l40_cy",   {7'd0, cy_log[b40+60]}, 12'd2);
    chk("l40_cx60", {7'd0, cx_log[b40+60]}, 12'd3);
    chk("l40_sf60", {8'd0, sf_log[b40+60]}, 12'd4);
    chk("l40_x59",  out_of(b40+59),  BG_E);
    chk("l40_x60",  out_of(b40+60),  12'h0C0);
    chk("l40_x79",  out_of(b40+79),  12'h0C0);
    chk("l40_x80",  out_of(b40+80),  BG_E);
    chk("l40_x100", out_of(b40+100), BG_E);
    chk("l40_x108", out_of(b40+108), 12'h0C0);
    chk("l40_x150", out_of(b40+150), BG_E);

    for (int y = 41; y < 48; y++) begin
      step(10'd0, 10'(y), 1'b0, 1'b1, 1'b1);
      step(10'd639, 10'(y), 1'b0, 1'b1, 1'b1);
    end
    b48 = cyc;
    walk(10'd48, 0, 110, 640);
    step(10'd111, 10'd48, 1'b1, 1'b0, 1'b0);
    step(10'd112, 10'd48, 1'b1, 1'b0, 1'b0);
    step(10'd113, 10'd48, 1'b1, 1'b0, 1'b0);
    chk("l48_x60",  out_of(b48+60),  12'h0C0);
    chk("l48_x100", out_of(b48+100), BG_E);
    chk("l48_x101", out_of(b48+101), 12'h000);
    chk("l48_x108", out_of(b48+108), 12'hF00);
    chk("l48_pre_rgb", {vga_r, vga_g, vga_b}, 12'hF00);
    chk("l48_pre_hs", {11'd0, hsync}, 12'd0);

    #7 reset = 1'b1;
    #1;
    chk("mid_rst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
    chk("mid_rst_hs", {11'd0, hsync}, 12'd1);
    chk("mid_rst_vs", {11'd0, vsync}, 12'd1);
    chk("mid_rst_sf", {8'd0, selected_figure}, 12'd10);
    step(10'd114, 10'd48, 1'b1, 1'b0, 1'b0);
    chk("mid_rst_edge", {vga_r, vga_g, vga_b}, 12'h000);
    reset = 1'b0;
    step(10'd0, 10'd480, 1'b0, 1'b1, 1'b1);
    br = cyc;
    walk(10'd0, 0, 30, 640);
    step(10'd31, 10'd0, 1'b1, 1'b1, 1'b1);
    step(10'd32, 10'd0, 1'b1, 1'b1, 1'b1);
    chk("rs_x0",  out_of(br+0),  BG_E);
    chk("rs_x20", out_of(br+20), 12'hFFF);
    chk("rs_x24", out_of(br+24), BG_E);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
